// File: rtl/alu_uart_pkg.sv
// Shared types and constants for the ALU result transmitter.
// ALU_RESULT_TX_CHECKSUM_EN selects the 4-byte frame with a trailing XOR checksum.
package alu_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } tx_state_t;

   localparam int FRAME_LEN_PLAIN = 3;
   localparam int FRAME_LEN_CSUM  = 4;
`ifdef ALU_RESULT_TX_CHECKSUM_EN
   localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
   localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif

   localparam int FLAG_BIT_ZERO = 0;
   localparam int FLAG_BIT_COUT = 1;

   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

   typedef struct packed {
      logic [7:0] data;
      logic       zero;
      logic       cout;
`ifdef ALU_RESULT_TX_CHECKSUM_EN
      logic [7:0] csum;
`endif
   } frame_t;

   function automatic logic [7:0] flags_byte(input logic zero, input logic cout);
      logic [7:0] f;
      f = '0;
      f[FLAG_BIT_ZERO] = zero;
      f[FLAG_BIT_COUT] = cout;
      return f;
   endfunction

endpackage

// File: rtl/alu_frame_buf.sv
// Active frame register plus a one-entry pending slot with overflow flag.
// With ALU_RESULT_TX_CHECKSUM_EN the checksum byte is computed here at capture.
module alu_frame_buf
   import alu_uart_pkg::*;
`ifdef ALU_RESULT_TX_CHECKSUM_EN
#(
   parameter logic [7:0] HEADER = DEFAULT_HEADER
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   input  logic       i_zero,
   input  logic       i_cout,
   input  logic       i_take_active,
   input  logic       i_promote,
   output frame_t     o_active,
   output logic       o_pend_full,
   output logic       o_overflow
);

   frame_t r_active;
   frame_t r_pend;
   logic   r_pend_full;
   logic   r_overflow;
   frame_t w_new;

   always_comb begin
      w_new.data = i_data;
      w_new.zero = i_zero;
      w_new.cout = i_cout;
`ifdef ALU_RESULT_TX_CHECKSUM_EN
      w_new.csum = HEADER ^ i_data ^ flags_byte(i_zero, i_cout);
`endif
   end

   // A strobe coinciding with promotion refills the slot being vacated.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_active    <= '0;
         r_pend      <= '0;
         r_pend_full <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (i_promote) begin
         r_active <= r_pend;
         if (i_valid) begin
            r_pend <= w_new;
         end else begin
            r_pend_full <= 1'b0;
         end
      end else if (i_valid) begin
         if (i_take_active) begin
            r_active <= w_new;
         end else if (!r_pend_full) begin
            r_pend      <= w_new;
            r_pend_full <= 1'b1;
         end else begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_active    = r_active;
   assign o_pend_full = r_pend_full;
   assign o_overflow  = r_overflow;

endmodule

// File: rtl/alu_result_tx.sv
// Serialises captured ALU results as HEADER/data/flags[/checksum] frames over uart_tx.
// ALU_RESULT_TX_CHECKSUM_EN adds the XOR checksum byte (4-byte frames).
//
// state   | meaning
// IDLE    | no frame in flight, waiting for a result strobe
// LOAD    | latch frame byte[idx] onto tx_data
// SEND    | en_tx high until uart_tx reports tx_d_end
// GAP     | en_tx low for GAP_CYCLES clocks before next byte/frame
module alu_result_tx
   import alu_uart_pkg::*;
#(
   parameter logic [7:0] HEADER     = DEFAULT_HEADER,
   parameter int         GAP_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       res_valid,
   input  logic [7:0] res_data,
   input  logic       res_zero,
   input  logic       res_cout,
   input  logic       tx_d_end,
   output logic [7:0] tx_data,
   output logic       en_tx,
   output logic       busy,
   output logic       overflow
);

   localparam logic [1:0] LAST_IDX  = 2'(FRAME_LEN - 1);
   localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYCLES - 1);

   tx_state_t  r_state;
   tx_state_t  w_state_nxt;
   logic [1:0] r_idx;
   logic [1:0] w_idx_nxt;
   logic [7:0] r_gap_cnt;
   logic [7:0] w_gap_cnt_nxt;
   logic [7:0] r_tx_data;
   logic [7:0] w_tx_data_nxt;
   logic       r_en_tx;
   logic       w_en_tx_nxt;
   logic       r_busy;
   logic       w_busy_nxt;

   frame_t     w_active;
   logic       w_pend_full;
   logic       w_overflow;
   logic       w_gap_done;
   logic       w_frame_done;
   logic       w_take_active;
   logic       w_promote;
   logic [7:0] w_byte;

   assign w_gap_done    = (r_state == ST_GAP) && (r_gap_cnt == 8'd0);
   assign w_frame_done  = w_gap_done && (r_idx == LAST_IDX);
   // Final GAP exit with nothing pending behaves like IDLE so a new result skips the bubble.
   assign w_take_active = (r_state == ST_IDLE) || (w_frame_done && !w_pend_full);
   assign w_promote     = w_frame_done && w_pend_full;

   alu_frame_buf
`ifdef ALU_RESULT_TX_CHECKSUM_EN
   #(
      .HEADER(HEADER)
   )
`endif
   u_frame_buf (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_valid      (res_valid),
      .i_data       (res_data),
      .i_zero       (res_zero),
      .i_cout       (res_cout),
      .i_take_active(w_take_active),
      .i_promote    (w_promote),
      .o_active     (w_active),
      .o_pend_full  (w_pend_full),
      .o_overflow   (w_overflow)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_idx     <= 2'd0;
         r_gap_cnt <= 8'd0;
         r_tx_data <= 8'd0;
         r_en_tx   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
         r_tx_data <= w_tx_data_nxt;
         r_en_tx   <= w_en_tx_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (res_valid) w_state_nxt = ST_LOAD;
         ST_LOAD: w_state_nxt = ST_SEND;
         ST_SEND: if (tx_d_end) w_state_nxt = ST_GAP;
         ST_GAP: begin
            if (w_gap_done) begin
               if (r_idx != LAST_IDX || w_pend_full || res_valid) begin
                  w_state_nxt = ST_LOAD;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_byte = 8'd0;
      case (r_idx)
         2'd0: w_byte = HEADER;
         2'd1: w_byte = w_active.data;
         2'd2: w_byte = flags_byte(w_active.zero, w_active.cout);
`ifdef ALU_RESULT_TX_CHECKSUM_EN
         2'd3: w_byte = w_active.csum;
`endif
         default: w_byte = 8'd0;
      endcase
   end

   always_comb begin
      w_idx_nxt     = r_idx;
      w_gap_cnt_nxt = r_gap_cnt;
      w_tx_data_nxt = r_tx_data;
      case (r_state)
         ST_LOAD: w_tx_data_nxt = w_byte;
         ST_SEND: if (tx_d_end) w_gap_cnt_nxt = GAP_RELOAD;
         ST_GAP: begin
            if (w_gap_done) begin
               w_idx_nxt = (r_idx != LAST_IDX) ? r_idx + 2'd1 : 2'd0;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt - 8'd1;
            end
         end
         default: ;
      endcase
      w_en_tx_nxt = (w_state_nxt == ST_SEND);
      w_busy_nxt  = (r_state != ST_IDLE) || w_pend_full;
   end

   assign tx_data  = r_tx_data;
   assign en_tx    = r_en_tx;
   assign busy     = r_busy;
   assign overflow = w_overflow;

endmodule
